program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 104 ++++++++++
 tb/tb_program_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// Holds the fetch PC of a single-cycle MIPS-style core and computes the next
// PC from the current instruction: sequential (pc+4), J/JAL pseudo-direct
// jump, JR register jump and BEQ/BNE PC-relative branches. The PC only
// advances when the pipeline is allowed to move on, which is pc_en together
// with the memory hit that the current instruction is waiting on: dhit for
// loads/stores, ihit for everything else. JAL also produces the register file
// link write (r31 <= pc+4) in the cycle the jump is taken.
//
// Ports
//   CLK          in   rising-edge clock
//   nRST         in   asynchronous reset, active-high (despite the name)
//   pc_en        in   global PC update enable
//   instruction  in   [31:0] current instruction
//   ihit         in   instruction memory access complete
//   dhit         in   data memory access complete
//   rdat1        in   [31:0] register file read port 1 (rs)
//   rdat2        in   [31:0] register file read port 2 (rt)
//   pc           out  [31:0] current PC (instruction memory address)
//   pc_plus4     out  [31:0] pc + 4
//   link_wen     out  link register write enable (JAL taken)
//   link_wsel    out  [4:0] link register index, always 31
//   link_wdat    out  [31:0] link data, equal to pc_plus4
// ---------------------------------------------------------------------------
module program_counter #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic [31:0] instruction,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] rdat1,
  input  logic [31:0] rdat2,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        link_wen,
  output logic [4:0]  link_wsel,
  output logic [31:0] link_wdat
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               is_mem;
  logic               advance;
  logic               br_taken;
  logic signed [31:0] br_off;
  logic [31:0]        npc;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign pc_plus4 = pc + 32'd4;

  // Loads and stores wait on the data side; everything else on fetch.
  assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
  assign advance = pc_en && (is_mem ? dhit : ihit);

  // Word offset: sign-extend the 16-bit immediate, then scale by 4.
  assign br_off = $signed({{14{instruction[15]}}, instruction[15:0], 2'b00});

  always_comb begin
    br_taken = 1'b0;
    npc      = pc_plus4;
    case (opcode)
      OP_J, OP_JAL: npc = {pc_plus4[31:28], instruction[25:0], 2'b00};
      OP_RTYPE: begin
        if (funct == FN_JR)
          npc = rdat1;
      end
      OP_BEQ: br_taken = (rdat1 == rdat2);
      OP_BNE: br_taken = (rdat1 != rdat2);
      default: npc = pc_plus4;
    endcase
    // Modulo-2^32 add; wrap-around is intentional.
    if (br_taken)
      npc = pc_plus4 + $unsigned(br_off);
  end

  // PC register: reset dominates any pending update.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST)
      pc <= PC_INIT;
    else if (advance)
      pc <= npc;
  end

  // The link write is qualified by reset so it is low while reset is held.
  assign link_wen  = !nRST && (opcode == OP_JAL) && advance;
  assign link_wsel = 5'd31;
  assign link_wdat = pc_plus4;

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//
// Directed bench for program_counter. A behavioural reference PC follows the
// instruction-set rules with plain integer arithmetic; a compare process
// checks every DUT output against it on each falling clock edge. Directed
// steps also check hand-computed literal PC values.
// ---------------------------------------------------------------------------
module tb_program_counter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en;
  logic [31:0] instruction;
  logic        ihit;
  logic        dhit;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        link_wen;
  logic [4:0]  link_wsel;
  logic [31:0] link_wdat;

  int total = 0;
  int bad   = 0;

  program_counter #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .instruction(instruction),
    .ihit(ihit), .dhit(dhit), .rdat1(rdat1), .rdat2(rdat2),
    .pc(pc), .pc_plus4(pc_plus4), .link_wen(link_wen),
    .link_wsel(link_wsel), .link_wdat(link_wdat)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] I_ADD = 32'h0022_1820;            // add $3,$1,$2
  localparam logic [31:0] I_JR  = 32'h03E0_0008;            // jr $31

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;

  function automatic bit m_advance(input logic [31:0] ins, input bit en, input bit ih, input bit dh);
    int op = int'(ins[31:26]);
    if (!en) return 0;
    if (op == 35 || op == 43) return dh;
    return ih;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] p, input logic [31:0] ins,
                                         input logic [31:0] a, input logic [31:0] b);
    longint seq = (longint'(p) + 4) % 64'h1_0000_0000;
    int     op  = int'(ins[31:26]);
    longint imm;
    if (op == 2 || op == 3)
      return 32'((seq / 64'h1000_0000) * 64'h1000_0000 + longint'(ins[25:0]) * 4);
    if (op == 0 && ins[5:0] == 6'd8)
      return a;
    if ((op == 4 && a == b) || (op == 5 && a != b)) begin
      imm = longint'(ins[15:0]);
      if (imm >= 32768) imm = imm - 65536;
      return 32'((seq + imm * 4 + 64'h1_0000_0000) % 64'h1_0000_0000);
    end
    return 32'(seq);
  endfunction

  always @(posedge CLK or posedge nRST) begin
    if (nRST)
      m_pc <= 32'h0;
    else if (m_advance(instruction, pc_en, ihit, dhit))
      m_pc <= m_next(m_pc, instruction, rdat1, rdat2);
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    logic [31:0] e4;
    e4 = m_pc + 32'd4;
    chk("pc_model", pc, m_pc);
    chk("pc_plus4_model", pc_plus4, e4);
    chk("link_wdat_model", link_wdat, e4);
    chk("link_wsel_model", {27'd0, link_wsel}, 32'd31);
    chk("link_wen_model", {31'd0, link_wen},
        {31'd0, (!nRST && instruction[31:26] == 6'd3 &&
                 m_advance(instruction, pc_en, ihit, dhit))});
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Load an arbitrary PC through a taken JR.
  task automatic set_pc(input logic [31:0] v);
    instruction = I_JR;
    rdat1 = v;
    pc_en = 1'b1;
    ihit  = 1'b1;
    step();
  endtask

  initial begin
    nRST = 1'b1; pc_en = 1'b1; ihit = 1'b1; dhit = 1'b0;
    instruction = I_ADD; rdat1 = 32'h0; rdat2 = 32'h0;
    #1;
    chk("reset_async", pc, 32'h0);
    chk("reset_link_wen", {31'd0, link_wen}, 32'd0);

    // Reset hold then release: 0, 4, 8, 12.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", pc, 32'h0);
    end
    nRST = 1'b0;
    #1;
    chk("release", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("post_reset_seq", pc, 32'(4 * i));
    end

    // Stall with a JAL pending: no movement and no link write.
    set_pc(32'h10);
    chk("set_0x10", pc, 32'h10);
    instruction = {6'b000011, 26'hABCD};
    ihit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ihit", pc, 32'h10);
      chk("stall_ihit_link", {31'd0, link_wen}, 32'd0);
    end
    ihit = 1'b1; pc_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_en", pc, 32'h10);
      chk("stall_en_link", {31'd0, link_wen}, 32'd0);
    end

    // JAL from 0x20.
    set_pc(32'h20);
    instruction = {6'b000011, 26'hABCD};
    #1;
    chk("jal_wen", {31'd0, link_wen}, 32'd1);
    chk("jal_wsel", {27'd0, link_wsel}, 32'd31);
    chk("jal_wdat", link_wdat, 32'h24);
    step();
    chk("jal_target", pc, 32'h0002_AF34);
    chk("jal_wen_after", {31'd0, link_wen}, 32'd1);

    // Branches from 0x100 with imm = -2.
    set_pc(32'h100);
    instruction = {6'b000100, 5'd1, 5'd2, 16'hFFFE}; rdat1 = 32'd5; rdat2 = 32'd5;
    step();
    chk("beq_taken", pc, 32'hFC);
    set_pc(32'h100);
    instruction = {6'b000100, 5'd1, 5'd2, 16'hFFFE}; rdat1 = 32'd5; rdat2 = 32'd6;
    step();
    chk("beq_not_taken", pc, 32'h104);
    set_pc(32'h100);
    instruction = {6'b000101, 5'd1, 5'd2, 16'hFFFE}; rdat1 = 32'd5; rdat2 = 32'd6;
    step();
    chk("bne_taken", pc, 32'hFC);
    set_pc(32'h100);
    instruction = {6'b000101, 5'd1, 5'd2, 16'h0010}; rdat1 = 32'd7; rdat2 = 32'd7;
    step();
    chk("bne_not_taken", pc, 32'h104);

    // JR then load/store gating on dhit.
    set_pc(32'h400);
    chk("jr", pc, 32'h400);
    instruction = {6'b100011, 5'd1, 5'd2, 16'h0004}; ihit = 1'b1; dhit = 1'b0;
    step();
    chk("lw_wait", pc, 32'h400);
    dhit = 1'b1;
    step();
    chk("lw_done", pc, 32'h404);
    instruction = {6'b101011, 5'd1, 5'd2, 16'h0004}; ihit = 1'b0; dhit = 1'b1;
    step();
    chk("sw_done", pc, 32'h408);
    instruction = I_ADD; ihit = 1'b0; dhit = 1'b1;
    step();
    chk("add_ignores_dhit", pc, 32'h408);
    dhit = 1'b0; ihit = 1'b1;

    // Wrap at the top of the address space.
    set_pc(32'hFFFF_FFFC);
    instruction = I_ADD;
    #1;
    chk("wrap_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap", pc, 32'h0);

    // Unaligned JR is loaded unchanged.
    set_pc(32'h0000_0013);
    chk("jr_unaligned", pc, 32'h13);
    instruction = I_ADD;
    step();
    chk("unaligned_seq", pc, 32'h17);

    // Mid-cycle reset with a JAL pending.
    instruction = {6'b000011, 26'h0000_100};
    #2;
    nRST = 1'b1;
    #1;
    chk("mid_reset_pc", pc, 32'h0);
    chk("mid_reset_link", {31'd0, link_wen}, 32'd0);
    step();
    chk("mid_reset_hold", pc, 32'h0);
    nRST = 1'b0;
    step();
    chk("after_mid_reset", pc, 32'h400);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
